// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OWN0, OWN1)
//   PORT_CPU/PORT_DMA : requester indices into the 2-bit valid/grant vectors
//   dmem_req_t  : one request beat {we, addr, wdata} at the default widths
//   own_state() : maps a port index to the matching ownership state
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic arb_state_t own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker with burst hold for two requesters.
// Holds no state: the arbiter top owns the state/last/count registers.
//   i_valid      : request valid per port
//   i_state      : current arbiter state
//   i_last       : last port served (loses a tie from IDLE)
//   i_count      : beats granted to the current owner (saturating)
//   o_grant      : one-hot grant (or zero)
//   o_next_state, o_next_last, o_next_count : register next values
module rr_pick2
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic [1:0]       i_valid,
  input  arb_state_t       i_state,
  input  logic             i_last,
  input  logic [CNT_W-1:0] i_count,
  output logic [1:0]       o_grant,
  output arb_state_t       o_next_state,
  output logic             o_next_last,
  output logic [CNT_W-1:0] o_next_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic w_pick;   // port chosen from IDLE
  logic w_own;    // current owner while in OWNx
  logic w_stay;   // owner keeps the bus this cycle

  always_comb begin
    o_grant      = 2'b00;
    o_next_state = i_state;
    o_next_last  = i_last;
    o_next_count = i_count;
    w_pick       = 1'b0;
    w_own        = (i_state == OWN1);
    w_stay       = 1'b0;

    case (i_state)
      IDLE: begin
        if (|i_valid) begin
          // On a tie the port that was not served last wins.
          w_pick           = (&i_valid) ? ~i_last : i_valid[PORT_DMA];
          o_grant[w_pick]  = 1'b1;
          o_next_state     = own_state(w_pick);
          o_next_count     = CNT_ONE;
        end
      end
      OWN0, OWN1: begin
        // The owner may exceed the burst limit only while the other port is idle.
        w_stay = i_valid[w_own] && ((i_count < CNT_MAX) || !i_valid[~w_own]);
        if (w_stay) begin
          o_grant[w_own] = 1'b1;
          if (i_count < CNT_MAX) begin
            o_next_count = i_count + CNT_ONE;
          end
        end else if (i_valid[~w_own]) begin
          o_grant[~w_own] = 1'b1;
          o_next_state    = own_state(~w_own);
          o_next_count    = CNT_ONE;
          o_next_last     = w_own;
        end else begin
          o_next_state = IDLE;
          o_next_last  = w_own;
        end
      end
      default: o_next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory
// (combinational read, clocked write). Port 0 is the CPU load/store unit,
// port 1 the program/data loader.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata : request from port N
//   reqN_ready          : grant, same cycle as valid
//   reqN_rvalid/rdata   : registered read response, one cycle after grant
//   mem_addr/we/wd      : memory drive, muxed from the granted port
//   mem_rd              : memory combinational read data
//   o_dbg_state/last/count : FSM registers exposed for observation
//
// Handshake: a beat transfers in a cycle where valid & ready are both high.
// ready is a combinational function of valid and the FSM, never high
// without valid, and at most one port's ready is high per cycle. A
// requester keeps addr/we/wdata stable while valid & !ready. rvalid is a
// one-cycle pulse per granted read with no back-pressure; rdata holds
// until that port's next read response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req0_valid,
  input  logic                             req0_we,
  input  logic [ADDR_W-1:0]                req0_addr,
  input  logic [DATA_W-1:0]                req0_wdata,
  output logic                             req0_ready,
  output logic                             req0_rvalid,
  output logic [DATA_W-1:0]                req0_rdata,
  input  logic                             req1_valid,
  input  logic                             req1_we,
  input  logic [ADDR_W-1:0]                req1_addr,
  input  logic [DATA_W-1:0]                req1_wdata,
  output logic                             req1_ready,
  output logic                             req1_rvalid,
  output logic [DATA_W-1:0]                req1_rdata,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic                             mem_we,
  output logic [DATA_W-1:0]                mem_wd,
  input  logic [DATA_W-1:0]                mem_rd,
  output arb_state_t                       o_dbg_state,
  output logic                             o_dbg_last,
  output logic [$clog2(MAX_BURST+1)-1:0]   o_dbg_count
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t       r_state, w_next_state;
  logic             r_last, w_next_last;
  logic [CNT_W-1:0] r_count, w_next_count;
  logic [1:0]       w_valid, w_pick_grant, w_grant;
  req_t             w_req0, w_req1, w_sel;
  logic             r_rvalid0, r_rvalid1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  assign w_valid = {req1_valid, req0_valid};

  rr_pick2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .i_valid      (w_valid),
    .i_state      (r_state),
    .i_last       (r_last),
    .i_count      (r_count),
    .o_grant      (w_pick_grant),
    .o_next_state (w_next_state),
    .o_next_last  (w_next_last),
    .o_next_count (w_next_count)
  );

  // Grants are forced low while reset is asserted so no memory write can
  // slip through during reset.
  assign w_grant    = w_pick_grant & {2{rst_n}};
  assign req0_ready = w_grant[PORT_CPU];
  assign req1_ready = w_grant[PORT_DMA];

  // With no grant the port-0 request drives the address/data lines.
  assign w_req0   = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign w_req1   = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
  assign w_sel    = w_grant[PORT_DMA] ? w_req1 : w_req0;
  assign mem_addr = w_sel.addr;
  assign mem_wd   = w_sel.wdata;
  assign mem_we   = (|w_grant) & w_sel.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
      r_count <= w_next_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_grant[PORT_CPU] & ~req0_we;
      r_rvalid1 <= w_grant[PORT_DMA] & ~req1_we;
      if (w_grant[PORT_CPU] && !req0_we) begin
        r_rdata0 <= mem_rd;
      end
      if (w_grant[PORT_DMA] && !req1_we) begin
        r_rdata1 <= mem_rd;
      end
    end
  end

  assign req0_rvalid = r_rvalid0;
  assign req0_rdata  = r_rdata0;
  assign req1_rvalid = r_rvalid1;
  assign req1_rdata  = r_rdata1;

  assign o_dbg_state = r_state;
  assign o_dbg_last  = r_last;
  assign o_dbg_count = r_count;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 = CPU load/store unit, port 1 = program/data loader (DMA).
- Grants at most one access per cycle, using round-robin with a bounded burst-hold counter.
- Drives the memory's address, write-enable and write-data inputs.
- Returns read data registered, one cycle after the grant.
- Sits between the core/loader and the data memory, whose read is combinational and whose write is clocked.

Parameters:
ADDR_W, 32, address width passed unchanged to memory (word address)
DATA_W, 32, data width
MAX_BURST, 4, max consecutive granted beats for one owner while the other port is requesting (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  CPU access request
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  CPU address
req0_wdata  in  DATA_W  CPU write data
req0_ready  out  1  grant; transfer occurs when valid & ready
req0_rvalid  out  1  read response pulse
req0_rdata  out  DATA_W  read response data
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata  as port 0, for loader
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wd  out  DATA_W  memory write data
mem_rd  in  DATA_W  memory combinational read data

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registers: state, last (last-served port), beat count (width clog2(MAX_BURST+1), saturating).
- Reset (async, rst_n=0): state=IDLE, last=1 (port 0 wins the first tie), count=0, reqN_rvalid=0, reqN_rdata=0.
- Combinational outputs held at zero while in reset: reqN_ready=0, mem_we=0.
- Grant selection is combinational, in the same cycle as valid. ready is never asserted without valid.
- IDLE:
  - One port valid: grant it.
  - Both valid: grant port != last.
  - Then go to OWNx with count=1.
  - Neither valid: stay IDLE, no grant.
- OWNx:
  - valid_x and (count<MAX_BURST or !valid_y): grant x, count=count+1 (saturating).
  - Else if valid_y: grant y, go to OWNy, count=1, last=x.
  - Else: go to IDLE, last=x, no grant.
- Exactly one ready high at most per cycle.
- Memory drive:
  - mem_addr/mem_wd are muxed from the granted port.
  - With no grant, mem_addr/mem_wd hold the port-0 values.
  - mem_we = granted & granted_we, which is the only write path.
- Read response:
  - On a granted read, rdata_q <= mem_rd, and the granted port's rvalid goes to 1 on the next edge for exactly one cycle.
  - reqN_rdata holds its value until the next read to that port.
  - A write never produces rvalid.
- Back-to-back reads are allowed every cycle: rvalid may stay high across consecutive cycles, one per beat.
- A requester must hold addr/we/wdata stable while valid & !ready. The arbiter does not check this.
- Read-after-write to the same address on consecutive grants returns the new data, because the memory write completes at the edge before the next combinational read.
- Reset asserted mid-operation: a pending rvalid is dropped and no memory write occurs during reset. After release, arbitration restarts from IDLE with port 0 preferred.
- MAX_BURST=1 degenerates to strict alternation under contention.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum arb_state_t {IDLE, OWN0, OWN1};
  - constants PORT_CPU=0, PORT_DMA=1;
  - request struct {we, addr, wdata}.
- Sub-module rr_pick2 is natural: inputs valid[1:0], state, last, count → outputs grant one-hot and next state/count. It is combinational and the FSM registers stay in the top.

Test Plan:
- Reset, then req0 write addr 5 data 0xDEADBEEF with port 1 idle → req0_ready same cycle, mem_we=1, mem_addr=5. Next cycle req0 read addr 5 → req0_rvalid=1 one cycle later, rdata=0xDEADBEEF.
- Both ports valid from IDLE after reset → port 0 granted first. Both held valid with MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0.
- Port 1 streams 10 reads (addr 0..9) alone → ready every cycle, count saturates, no forced switch; rvalid high 10 consecutive cycles with data matching addr.
- Port 0 owning at count=2 drops valid while port 1 is valid → port 1 granted that same cycle, state OWN1, count=1.
- Assert rst_n=0 the cycle after a granted read → no rvalid; after release ready=0 until a valid arrives; tie goes to port 0.
- Writes from both ports to addr 3 (0x11 from port 0 first, then 0x22 from port 1), then a port-0 read of addr 3 → 0x22. Bench also checks ready0&ready1 is never high in the same cycle.
